// File: rtl/hydra_pkg.sv
// hydra_pkg: shared types, defaults and helpers for the hydra read-side scheduler.
package hydra_pkg;

    localparam int unsigned DEF_PRIOR_NUM = 8;
    localparam int unsigned DEF_CNT_W     = 9;
    localparam int unsigned CREDIT_W      = 4;

    typedef logic [2:0] prior_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } rd_sched_state_t;

    // WRR weight of queue q: higher priority queues get proportionally more turns.
    function automatic logic [CREDIT_W-1:0] wrr_weight(input int unsigned q);
        return CREDIT_W'(q + 1);
    endfunction

endpackage

// File: rtl/prior_encoder_8_3.sv
// prior_encoder_8_3: combinational highest-set-bit encoder, 8-bit mask to 3-bit index.
module prior_encoder_8_3
    import hydra_pkg::*;
(
    input  logic [7:0] mask,
    output prior_t     idx,
    output logic       vld
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                idx = prior_t'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_rd_scheduler.sv
// port_rd_scheduler: per-output-port dequeue scheduler. Counts queued packets per
// priority queue and grants one queue at a time via a req/ack handshake, waiting for
// the packet's last word before arbitrating again. Strict priority by default;
// weighted round-robin is compiled in when HYDRA_RD_SCHED_WRR_EN is defined.
module port_rd_scheduler
    import hydra_pkg::*;
#(
    parameter int unsigned PRIOR_NUM = DEF_PRIOR_NUM,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrr_en,
    input  logic                 enq_vld,
    input  logic [2:0]           enq_prior,
    input  logic                 ready,
    output logic                 deq_req,
    output logic [2:0]           deq_prior,
    input  logic                 deq_ack,
    input  logic                 deq_done,
    output logic [PRIOR_NUM-1:0] q_nonempty,
    output logic                 cnt_ovf
);

    rd_sched_state_t      state_q, state_d;
    prior_t               deq_prior_q, deq_prior_d;
    logic [CNT_W-1:0]     cnt_q [PRIOR_NUM];
    logic [CNT_W-1:0]     cnt_d [PRIOR_NUM];
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 arb_go;
    logic [PRIOR_NUM-1:0] inc_vec, dec_vec;
    logic [PRIOR_NUM-1:0] sel_mask;
    prior_t               sel_idx;
    logic                 sel_vld;

    assign accept = (state_q == GRANT) && deq_ack;
    assign arb_go = (state_q == IDLE) && ready && (q_nonempty != '0);

    assign deq_req   = (state_q == GRANT);
    assign deq_prior = deq_prior_q;
    assign cnt_ovf   = ovf_q;

    // Per-queue occupancy flags straight from the counter registers
    always_comb begin
        q_nonempty = '0;
        for (int q = 0; q < PRIOR_NUM; q++) begin
            q_nonempty[q] = (cnt_q[q] != '0);
        end
    end

    // One-hot enqueue and accept strobes per queue
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        inc_vec[enq_prior]   = enq_vld;
        dec_vec[deq_prior_q] = accept;
    end

    // Counter next state: simultaneous inc/dec cancels, saturated enqueue is dropped
    always_comb begin
        ovf_d = ovf_q;
        for (int q = 0; q < PRIOR_NUM; q++) begin
            cnt_d[q] = cnt_q[q];
            if (inc_vec[q] && !dec_vec[q]) begin
                if (&cnt_q[q]) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d[q] = cnt_q[q] + CNT_W'(1);
                end
            end else if (dec_vec[q] && !inc_vec[q]) begin
                cnt_d[q] = cnt_q[q] - CNT_W'(1);
            end
        end
    end

`ifdef HYDRA_RD_SCHED_WRR_EN
    logic [CREDIT_W-1:0]  credit_q [PRIOR_NUM];
    logic [CREDIT_W-1:0]  credit_d [PRIOR_NUM];
    logic                 wrr_mode_q, wrr_mode_d;
    logic [PRIOR_NUM-1:0] credit_nz, elig;
    logic                 reload;

    // WRR eligibility; reload on entering WRR or when every nonempty queue is out
    // of credit, and select from the reloaded view in that same cycle.
    always_comb begin
        credit_nz = '0;
        for (int q = 0; q < PRIOR_NUM; q++) begin
            credit_nz[q] = (credit_q[q] != '0);
        end
        elig   = q_nonempty & credit_nz;
        reload = (state_q == IDLE) && wrr_en && (!wrr_mode_q || (arb_go && (elig == '0)));
        if (!wrr_en || reload) begin
            sel_mask = q_nonempty;
        end else begin
            sel_mask = elig;
        end
        // Mode is only sampled while idle, so a grant keeps the mode it was made under.
        wrr_mode_d = (state_q == IDLE) ? wrr_en : wrr_mode_q;
    end

    // Credit next state: reload, or charge the accepted queue one credit
    always_comb begin
        for (int q = 0; q < PRIOR_NUM; q++) begin
            credit_d[q] = reload ? wrr_weight(q) : credit_q[q];
            if (accept && wrr_mode_q && (deq_prior_q == prior_t'(q)) && (credit_q[q] != '0)) begin
                credit_d[q] = credit_q[q] - CREDIT_W'(1);
            end
        end
    end

    // Credit and mode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < PRIOR_NUM; q++) begin
                credit_q[q] <= wrr_weight(q);
            end
            wrr_mode_q <= 1'b0;
        end else begin
            for (int q = 0; q < PRIOR_NUM; q++) begin
                credit_q[q] <= credit_d[q];
            end
            wrr_mode_q <= wrr_mode_d;
        end
    end
`else
    logic unused_wrr_en;
    assign unused_wrr_en = wrr_en;

    // Strict priority only
    always_comb begin
        sel_mask = q_nonempty;
    end
`endif

    prior_encoder_8_3 u_prior_enc (
        .mask (sel_mask),
        .idx  (sel_idx),
        .vld  (sel_vld)
    );

    // Handshake FSM: arbitrate in IDLE, hold request in GRANT, wait for last word in XFER
    always_comb begin
        state_d     = state_q;
        deq_prior_d = deq_prior_q;
        unique case (state_q)
            IDLE: begin
                if (arb_go && sel_vld) begin
                    deq_prior_d = sel_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (deq_ack) begin
                    state_d = deq_done ? IDLE : XFER;
                end
            end
            XFER: begin
                if (deq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            deq_prior_q <= '0;
            ovf_q       <= 1'b0;
            for (int q = 0; q < PRIOR_NUM; q++) begin
                cnt_q[q] <= '0;
            end
        end else begin
            state_q     <= state_d;
            deq_prior_q <= deq_prior_d;
            ovf_q       <= ovf_d;
            for (int q = 0; q < PRIOR_NUM; q++) begin
                cnt_q[q] <= cnt_d[q];
            end
        end
    end

endmodule

// File: tb/tb_port_rd_scheduler.sv
// tb_port_rd_scheduler: directed and randomized checks of port_rd_scheduler against a
// transaction-level model (queue counts, credits, selection rules).
module tb_port_rd_scheduler;
    import hydra_pkg::*;

`ifdef HYDRA_RD_SCHED_WRR_EN
    localparam bit WRR_BUILT = 1'b1;
`else
    localparam bit WRR_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, wrr_en, enq_vld, ready, deq_ack, deq_done;
    logic [2:0] enq_prior, deq_prior;
    logic       deq_req, cnt_ovf;
    logic [7:0] q_nonempty;

    int checks = 0;
    int errors = 0;

    // Model state
    int mcnt  [8];
    int mcred [8];
    bit mmode;
    bit movf;
    bit cur_wrr;
    int granted [$];

    always #5 clk = ~clk;

    port_rd_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .wrr_en     (wrr_en),
        .enq_vld    (enq_vld),
        .enq_prior  (enq_prior),
        .ready      (ready),
        .deq_req    (deq_req),
        .deq_prior  (deq_prior),
        .deq_ack    (deq_ack),
        .deq_done   (deq_done),
        .q_nonempty (q_nonempty),
        .cnt_ovf    (cnt_ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reload();
        for (int q = 0; q < 8; q++) mcred[q] = q + 1;
    endtask

    task automatic m_reset();
        for (int q = 0; q < 8; q++) mcnt[q] = 0;
        m_reload();
        mmode = 1'b0;
        movf  = 1'b0;
    endtask

    // Bench changed wrr_en; the DUT sees it in an idle cycle before any further grant.
    task automatic m_set_wrr(input bit v);
        bit eff;
        eff = v && WRR_BUILT;
        if (eff && !mmode) m_reload();
        mmode = eff;
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        m = '0;
        for (int q = 0; q < 8; q++) m[q] = (mcnt[q] > 0);
        return m;
    endfunction

    task automatic m_pick(output int pick);
        pick = -1;
        if (mmode) begin
            for (int q = 7; q >= 0; q--) begin
                if (pick < 0 && mcnt[q] > 0 && mcred[q] > 0) pick = q;
            end
            if (pick < 0) m_reload();
        end
        for (int q = 7; q >= 0; q--) begin
            if (pick < 0 && mcnt[q] > 0) pick = q;
        end
        cur_wrr = mmode;
    endtask

    task automatic m_accept(input int q);
        if (q >= 0 && q < 8) begin
            mcnt[q]--;
            if (cur_wrr && mcred[q] > 0) mcred[q]--;
        end
    endtask

    task automatic m_enq(input int q);
        if (mcnt[q] == 511) movf = 1'b1;
        else mcnt[q]++;
    endtask

    // One-cycle enqueue pulse (used while ready=0 so no grant runs concurrently)
    task automatic enq(input int q);
        enq_vld   = 1'b1;
        enq_prior = 3'(q);
        tick();
        enq_vld   = 1'b0;
        m_enq(q);
    endtask

    task automatic wait_req();
        int w;
        w = 0;
        while (deq_req !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        check("req_timeout", deq_req, 1);
    endtask

    // Serve one packet: ack after ack_dly cycles; len=0 means done together with ack,
    // otherwise done after len cycles in XFER. last drops ready with the final handshake.
    task automatic serve_pkt(input int ack_dly, input int len, input bit last, input bit toggle);
        int exp;
        wait_req();
        if (deq_req !== 1'b1) return;
        m_pick(exp);
        granted.push_back(int'(deq_prior));
        check("deq_prior", deq_prior, exp);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check("req_hold", {deq_req, deq_prior}, {1'b1, 3'(exp)});
        end
        deq_ack  = 1'b1;
        deq_done = (len == 0);
        if (last && len == 0) ready = 1'b0;
        tick();
        deq_ack  = 1'b0;
        deq_done = 1'b0;
        m_accept(exp);
        if (len > 0) begin
            if (toggle) begin
                wrr_en = ~wrr_en;
                m_set_wrr(wrr_en);
            end
            for (int i = 1; i < len; i++) begin
                tick();
                check("xfer_no_req", deq_req, 0);
            end
            deq_done = 1'b1;
            if (last) ready = 1'b0;
            tick();
            deq_done = 1'b0;
        end
        check("q_nonempty", q_nonempty, m_mask());
        check("cnt_ovf", cnt_ovf, movf);
        check("idle_no_req", deq_req, 0);
        tick();
        check("next_req", deq_req, (ready && (m_mask() != 0)) ? 1 : 0);
    endtask

    initial begin
        int strict_exp [3];
        int n;
        int k;
        int total;
        strict_exp = '{5, 3, 1};
        rst = 1'b1; wrr_en = 1'b0; enq_vld = 1'b0; enq_prior = '0;
        ready = 1'b0; deq_ack = 1'b0; deq_done = 1'b0;
        m_reset();
        tick();
        tick();
        check("rst_deq_req", deq_req, 0);
        check("rst_deq_prior", deq_prior, 0);
        check("rst_q_nonempty", q_nonempty, 0);
        check("rst_cnt_ovf", cnt_ovf, 0);
        rst = 1'b0;
        m_set_wrr(1'b0);
        tick();

        // Strict order: burst into q1, q5, q3
        enq(1); enq(5); enq(3);
        check("strict_mask", q_nonempty, 8'b0010_1010);
        granted.delete();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) serve_pkt(0, 1, i == 2, 1'b0);
        for (int i = 0; i < 3; i++) check("strict_seq", granted[i], strict_exp[i]);
        check("strict_empty", q_nonempty, 0);

        // WRR fairness: q7 and q0 twenty packets each, continuous ack/done
        wrr_en = 1'b1;
        m_set_wrr(1'b1);
        tick();
        for (int i = 0; i < 20; i++) enq(7);
        for (int i = 0; i < 20; i++) enq(0);
        granted.delete();
        ready = 1'b1;
        for (int i = 0; i < 40; i++) serve_pkt(0, 0, i == 39, 1'b0);
        for (int i = 0; i < 18; i++) begin
            check("wrr_pattern", granted[i], (WRR_BUILT && (i % 9 == 8)) ? 0 : 7);
        end
        check("wrr_empty", q_nonempty, 0);
        wrr_en = 1'b0;
        m_set_wrr(1'b0);
        tick();

        // Enqueue and accept on q2 in the same cycle
        enq(2);
        ready = 1'b1;
        wait_req();
        begin
            int p;
            m_pick(p);
            check("simul_prior", deq_prior, p);
            deq_ack = 1'b1; deq_done = 1'b1;
            enq_vld = 1'b1; enq_prior = 3'd2;
            ready = 1'b0;
            tick();
            deq_ack = 1'b0; deq_done = 1'b0; enq_vld = 1'b0;
            m_accept(p);
            m_enq(2);
        end
        check("simul_mask", q_nonempty, m_mask());
        check("simul_q2", q_nonempty[2], 1);
        tick();
        check("simul_paused", deq_req, 0);
        ready = 1'b1;
        serve_pkt(1, 2, 1'b1, 1'b0);

        // Saturation of q4
        for (int i = 0; i < 511; i++) enq(4);
        check("sat_no_ovf", cnt_ovf, 0);
        enq(4);
        check("sat_ovf", cnt_ovf, 1);
        ready = 1'b1;
        for (int i = 0; i < 511; i++) serve_pkt(0, 0, i == 510, 1'b0);
        check("sat_q4_empty", q_nonempty[4], 0);
        check("sat_ovf_sticky", cnt_ovf, 1);

        // Pause, then reset during XFER
        enq(6);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pause_no_req", deq_req, 0);
        end
        ready = 1'b1;
        check("ready_cycle_no_req", deq_req, 0);
        tick();
        check("ready_req", deq_req, 1);
        check("ready_prior", deq_prior, 6);
        deq_ack = 1'b1;
        tick();
        deq_ack = 1'b0;
        enq_vld = 1'b1; enq_prior = 3'd3;
        tick();
        enq_vld = 1'b0;
        check("xfer_mask", q_nonempty, 8'b0000_1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("xrst_deq_req", deq_req, 0);
        check("xrst_deq_prior", deq_prior, 0);
        check("xrst_q_nonempty", q_nonempty, 0);
        check("xrst_cnt_ovf", cnt_ovf, 0);
        m_reset();
        m_set_wrr(wrr_en);
        tick();
        tick();
        check("xrst_stays_idle", deq_req, 0);
        ready = 1'b0;
        tick();

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            wrr_en = 1'($urandom_range(0, 1));
            m_set_wrr(wrr_en);
            tick();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) enq($urandom_range(0, 7));
            check("rnd_mask", q_nonempty, m_mask());
            total = 0;
            for (int q = 0; q < 8; q++) total += mcnt[q];
            k = $urandom_range(1, total);
            ready = 1'b1;
            for (int i = 0; i < k; i++) begin
                serve_pkt($urandom_range(0, 2), $urandom_range(0, 3), i == k - 1,
                          $urandom_range(0, 3) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
